// File: rtl/adriannovosel_quad_counter.sv
// adriannovosel_quad_counter
// Four-channel rising-edge event counter packaged as a Tiny Tapeout tile.
// Each channel input is synchronised and edge-detected, and drives a wrapping
// CNT_W-bit counter with a sticky overflow flag. One counter at a time is read
// out a byte at a time on uo_out; the overflow flags appear on uio_out[7:4].
// Optional build macro READ_SNAPSHOT_EN: the high byte is served from a
// snapshot taken while the low byte is selected, so a low-then-high read is
// coherent even if the counter moves between the two reads.
module adriannovosel_quad_counter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [SYNC_STAGES-1:0] sync [4];
    logic [3:0]             sync_out;
    logic [3:0]             prev;
    logic [3:0]             edges;
    logic [3:0]             inc;
    logic [3:0]             ovf;
    logic [CNT_W-1:0]       cnt [4];
    logic [CNT_W-1:0]       sel_cnt;
    logic [CNT_W-1:0]       hi_src;
    logic                   clr;
    logic [1:0]             sel;
    logic                   byte_hi;
    logic                   unused_uio;

    // High byte of a counter, zero-padded when CNT_W < 16.
    function automatic logic [7:0] hi_byte(input logic [CNT_W-1:0] v);
        logic [7:0] r;
        r = '0;
        r[CNT_W-9:0] = v[CNT_W-1:8];
        return r;
    endfunction

    assign sel        = ui_in[5:4];
    assign byte_hi    = ui_in[6];
    // Clear is gated by ena like counting, so a disabled tile ignores it.
    assign clr        = ena & ui_in[7];
    assign unused_uio = &{1'b0, uio_in[7:4]};

    // Synchroniser outputs, one-cycle rising-edge pulses and qualified increments.
    always_comb begin
        sync_out = '0;
        for (int i = 0; i < 4; i++) begin
            sync_out[i] = sync[i][SYNC_STAGES-1];
        end
        edges = sync_out & ~prev;
        inc   = edges & uio_in[3:0] & {4{ena & ~ui_in[7]}};
    end

    // Input synchronisers and edge history; these run regardless of ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                sync[i] <= '0;
            end
            prev <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync[i] <= {sync[i][SYNC_STAGES-2:0], ui_in[i]};
            end
            prev <= sync_out;
        end
    end

    // Counters and sticky overflow flags; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else if (clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (inc[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign sel_cnt = cnt[sel];

`ifdef READ_SNAPSHOT_EN
    logic [CNT_W-1:0] snapshot;

    // Track the selected counter while the low byte is being read; freeze it
    // once the high byte is selected so both bytes come from the same value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snapshot <= '0;
        end else if (clr) begin
            snapshot <= '0;
        end else if (!byte_hi) begin
            snapshot <= sel_cnt;
        end
    end

    assign hi_src = snapshot;
`else
    assign hi_src = sel_cnt;
`endif

    assign uo_out  = byte_hi ? hi_byte(hi_src) : sel_cnt[7:0];
    assign uio_out = {ovf, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_adriannovosel_quad_counter.sv
// tb_adriannovosel_quad_counter
// Directed bench: drives two instances from the same stimulus, the default
// CNT_W=16 build and a CNT_W=9 build whose wrap point is reachable quickly.
module tb_adriannovosel_quad_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [7:0] ui;
    logic [7:0] uio;
    logic [7:0] uo16, uioo16, oe16;
    logic [7:0] uo9, uioo9, oe9;

    int checks = 0;
    int errors = 0;

    logic [15:0] w16, w9;
    logic [15:0] exp_hi;

    always #5 clk = ~clk;

    adriannovosel_quad_counter #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui), .uo_out(uo16),
        .uio_in(uio), .uio_out(uioo16), .uio_oe(oe16)
    );

    adriannovosel_quad_counter #(.CNT_W(9), .SYNC_STAGES(2)) dut_w9 (
        .clk(clk), .rst(rst), .ena(ena), .ui_in(ui), .uo_out(uo9),
        .uio_in(uio), .uio_out(uioo9), .uio_oe(oe9)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch);
        ui[ch] = 1'b1;
        tick();
        ui[ch] = 1'b0;
        tick();
    endtask

    task automatic pulses(input int ch, input int n);
        for (int k = 0; k < n; k++) pulse(ch);
        repeat (3) tick();
    endtask

    // Low byte first (one clock on it), then high byte.
    task automatic read_word(input logic [1:0] ch, output logic [15:0] a, output logic [15:0] b);
        ui[5:4] = ch;
        ui[6]   = 1'b0;
        #1;
        a[7:0] = uo16;
        b[7:0] = uo9;
        tick();
        ui[6] = 1'b1;
        #1;
        a[15:8] = uo16;
        b[15:8] = uo9;
    endtask

    initial begin
        rst = 1'b1;
        ena = 1'b0;
        ui  = 8'h00;
        uio = 8'h00;
        repeat (3) tick();
        check("rst_uo", {8'h00, uo16}, 16'h0000);
        check("rst_uio", {8'h00, uioo16}, 16'h0000);
        check("uio_oe", {oe9, oe16}, 16'hF0F0);
        rst = 1'b0;
        tick();

        // Latency of first increment and a three-pulse count on ch0.
        ena = 1'b1;
        uio = 8'h0F;
        ui[0] = 1'b1;
        tick();
        tick();
        check("lat_k1", {8'h00, uo16}, 16'h0000);
        tick();
        check("lat_k2", {8'h00, uo16}, 16'h0001);
        ui[0] = 1'b0;
        tick();
        pulses(0, 2);
        check("ch0_3", {uo9, uo16}, 16'h0303);
        ui[5:4] = 2'd1;
        #1;
        check("ch1_sel", {8'h00, uo16}, 16'h0000);
        ui[5:4] = 2'd0;

        // Asynchronous reset mid-count.
        pulses(0, 2);
        check("ch0_5", {8'h00, uo16}, 16'h0005);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_uo", {uo9, uo16}, 16'h0000);
        check("async_rst_uio", {uioo9, uioo16}, 16'h0000);
        tick();
        rst = 1'b0;
        tick();

        // Per-channel enable, tile enable, level-held input.
        uio = 8'h0D;
        pulses(1, 4);
        ui[5:4] = 2'd1;
        #1;
        check("ch1_masked", {8'h00, uo16}, 16'h0000);
        uio = 8'h0F;
        ui[5:4] = 2'd0;
        pulses(0, 2);
        ena = 1'b0;
        pulses(0, 3);
        ena = 1'b1;
        repeat (3) tick();
        check("ena_hold", {8'h00, uo16}, 16'h0002);
        ena = 1'b0;
        ui[7] = 1'b1;
        tick();
        ui[7] = 1'b0;
        ena = 1'b1;
        tick();
        check("ena_blocks_clr", {8'h00, uo16}, 16'h0002);
        ui[3] = 1'b1;
        repeat (10) tick();
        ui[5:4] = 2'd3;
        #1;
        check("level_once", {8'h00, uo16}, 16'h0001);
        ui[3] = 1'b0;
        repeat (3) tick();

        // Clear coinciding with the ch3 increment edge: the edge is lost.
        ui[3] = 1'b1;
        tick();
        tick();
        ui[7] = 1'b1;
        tick();
        ui[7] = 1'b0;
        repeat (5) tick();
        check("clr_prio", {8'h00, uo16}, 16'h0000);
        ui[5:4] = 2'd0;
        #1;
        check("clr_all", {8'h00, uo16}, 16'h0000);
        ui[3] = 1'b0;
        repeat (3) tick();

        // Wrap and overflow on ch2.
        pulses(2, 256);
        read_word(2'd2, w16, w9);
        check("w16_256", w16, 16'h0100);
        check("w9_256", w9, 16'h0100);
        pulses(2, 255);
        read_word(2'd2, w16, w9);
        check("w9_511", w9, 16'h01FF);
        check("ovf_pre", {uioo9, uioo16}, 16'h0000);
        pulses(2, 1);
        read_word(2'd2, w16, w9);
        check("w16_512", w16, 16'h0200);
        check("w9_wrap", w9, 16'h0000);
        check("ovf_set", {uioo9, uioo16}, 16'h4000);
        pulses(2, 3);
        check("ovf_sticky", {8'h00, uioo9}, 16'h0040);
        ui[7] = 1'b1;
        tick();
        ui[7] = 1'b0;
        tick();
        check("ovf_clr", {uioo9, uioo16}, 16'h0000);
        read_word(2'd2, w16, w9);
        check("cnt_clr", w16 | w9, 16'h0000);

        // High-byte read after the counter moves past 0x00FF.
        ui[5:4] = 2'd0;
        ui[6]   = 1'b0;
        pulses(0, 255);
        check("lo_ff", {uo9, uo16}, 16'hFFFF);
        ui[6] = 1'b1;
        pulses(0, 1);
`ifdef READ_SNAPSHOT_EN
        exp_hi = 16'h0000;
`else
        exp_hi = 16'h0101;
`endif
        check("hi_read", {uo9, uo16}, exp_hi);
        ui[6] = 1'b0;
        #1;
        check("lo_live", {uo9, uo16}, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
